// File: rtl/onchip_ram_scrub.sv
// -----------------------------------------------------------------------------
// onchip_ram_scrub
//   Single-port on-chip RAM behind an Avalon-MM slave. It has a configurable
//   width, depth and read latency of 1 or 2 cycles. A built-in clear engine
//   zeroes every word after reset (when CLEAR_ON_RESET=1) or when clear_req_i
//   is pulsed. The bus is stalled with waitrequest while the clear runs.
//
// Ports
//   clk_i            system clock
//   reset_n_i        asynchronous active-low reset
//   address_i        word address (ADDR_W bits, so always modulo DEPTH)
//   chipselect_i     slave select
//   read_i           read request
//   write_i          write request (wins over read_i when both are set)
//   byteenable_i     byte-lane enables for writes
//   writedata_i      write data
//   readdata_o       read data; holds its last value between reads
//   readdatavalid_o  one-cycle strobe, RD_LAT cycles after a read is accepted
//   waitrequest_o    1 = request not accepted (clear engine running)
//   clear_req_i      pulse: start a full-array clear (ignored while clearing)
//   busy_o           1 while the clear engine runs
//   clear_done_o     one-cycle pulse when a clear completes
// -----------------------------------------------------------------------------
module onchip_ram_scrub #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic                chipselect_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [DATA_W/8-1:0] byteenable_i,
  input  logic [DATA_W-1:0]   writedata_i,
  output logic [DATA_W-1:0]   readdata_o,
  output logic                readdatavalid_o,
  output logic                waitrequest_o,
  input  logic                clear_req_i,
  output logic                busy_o,
  output logic                clear_done_o
);

  localparam int unsigned NUM_LANES = DATA_W / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  // The clear counter carries one spare bit so it never wraps back to 0.
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   clr_addr_q;
  logic [ADDR_W:0]   clr_addr_d;
  logic              busy_q;
  logic              waitrequest_q;
  logic              clear_done_q;

  assign clr_addr_d = clr_addr_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Clear engine FSM. The outputs are registered, so waitrequest and busy follow
  // the state exactly. clear_req_i is only looked at in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_IDLE;
      end
      busy_q        <= CLEAR_ON_RESET;
      waitrequest_q <= CLEAR_ON_RESET;
      clr_addr_q    <= '0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_req_i) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            busy_q        <= 1'b1;
            waitrequest_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q       <= ST_IDLE;
            clr_addr_q    <= '0;
            busy_q        <= 1'b0;
            waitrequest_q <= 1'b0;
            clear_done_q  <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single memory port, shared between the clear engine and the bus. The two
  // never collide because the bus is stalled for the whole clear.
  // ---------------------------------------------------------------------------
  logic                 clearing;
  logic                 bus_acc;
  logic                 bus_wr;
  logic                 bus_rd;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [NUM_LANES-1:0] mem_be;
  logic [DATA_W-1:0]    mem_rdata;

  assign clearing  = (state_q == ST_CLEAR);
  assign bus_acc   = chipselect_i & (read_i | write_i) & ~waitrequest_q;
  assign bus_wr    = bus_acc & write_i;
  assign bus_rd    = bus_acc & read_i & ~write_i;  // a read paired with a write is dropped
  assign mem_we    = clearing | bus_wr;
  assign mem_addr  = clearing ? clr_addr_q[ADDR_W-1:0] : address_i;
  assign mem_wdata = clearing ? '0 : writedata_i;
  assign mem_be    = clearing ? '1 : byteenable_i;

  // Each byte lane is its own array. This gives clean per-lane write enables.
  // The read register has a clock enable, so it keeps the last word read.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk_i) begin
        if (mem_we && mem_be[gi]) begin
          mem_q[mem_addr] <= mem_wdata[gi*8 +: 8];
        end
        if (bus_rd) begin
          rd_q <= mem_q[mem_addr];
        end
      end

      assign mem_rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read-latency pipeline. Only the valid bits and the optional output register
  // are reset. The RAM output register itself is not reset.
  // ---------------------------------------------------------------------------
  logic rd_v1_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v1_q <= 1'b0;
    end else begin
      rd_v1_q <= bus_rd;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd_v2_q;
      logic [DATA_W-1:0] rdata2_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          rd_v2_q  <= 1'b0;
          rdata2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q;
          if (rd_v1_q) begin
            rdata2_q <= mem_rdata;
          end
        end
      end

      assign readdatavalid_o = rd_v2_q;
      assign readdata_o      = rdata2_q;
    end else begin : g_lat1
      // The RAM register has no reset. Until the first read after reset, it is
      // masked to zero so that readdata still comes out of reset as 0.
      logic has_read_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          has_read_q <= 1'b0;
        end else if (bus_rd) begin
          has_read_q <= 1'b1;
        end
      end

      assign readdatavalid_o = rd_v1_q;
      assign readdata_o      = has_read_q ? mem_rdata : '0;
    end
  endgenerate

  assign waitrequest_o = waitrequest_q;
  assign busy_o        = busy_q;
  assign clear_done_o  = clear_done_q;

endmodule
